// File: rtl/fir_mac_engine.sv
// Multi-channel FIR engine: one rounded, saturated dot product of a circular sample
// window and a coefficient kernel per accepted start, read from external sync RAMs.
module fir_mac_engine #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 128,
  parameter int ADDR_W = $clog2(TAPS),
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int SHIFT  = 15,
  parameter int ACC_W  = DATA_W + COEF_W + ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [CH_W-1:0]        start_ch,
  input  logic [ADDR_W-1:0]      start_addr,
  input  logic [ADDR_W-1:0]      num_taps,
  output logic                   busy,
  output logic [CH_W+ADDR_W-1:0] audio_addr,
  input  logic [DATA_W-1:0]      audio_data,
  output logic [CH_W+ADDR_W-1:0] kernel_addr,
  input  logic [COEF_W-1:0]      kernel_data,
  output logic [DATA_W-1:0]      result,
  output logic [CH_W-1:0]        result_ch,
  output logic                   result_valid,
  output logic                   overflow,
  output logic [1:0]             fsm_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(64'd1 << (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'd1 << (DATA_W - 1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

  logic [1:0]               state;
  logic [CH_W-1:0]          ch_q;
  logic [ADDR_W-1:0]        last_q;
  logic [ADDR_W-1:0]        k_q;
  logic [ADDR_W-1:0]        s_q;
  logic                     drain_cnt;
  logic                     v1;
  logic                     v2;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  rounded;
  logic [DATA_W-1:0]        sat_val;
  logic                     sat_flag;
  logic                     accept;

  // Handshake: a request is taken on any rising edge where start=1 and busy=0;
  // busy stays high through the result_valid cycle, so start during busy is dropped.
  assign accept      = start && !busy;
  assign audio_addr  = {ch_q, s_q};
  assign kernel_addr = {ch_q, k_q};
  assign fsm_state   = state;

  assign acc_rnd = acc + RND;
  assign rounded = acc_rnd >>> SHIFT;

  always_comb begin
    sat_val  = rounded[DATA_W-1:0];
    sat_flag = 1'b0;
    if (rounded > MAXV) begin
      sat_val  = {1'b0, {(DATA_W-1){1'b1}}};
      sat_flag = 1'b1;
    end else if (rounded < MINV) begin
      sat_val  = {1'b1, {(DATA_W-1){1'b0}}};
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      ch_q         <= '0;
      last_q       <= '0;
      k_q          <= '0;
      s_q          <= '0;
      drain_cnt    <= 1'b0;
      result       <= '0;
      result_ch    <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (result_valid) busy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_ISSUE;
            busy   <= 1'b1;
            ch_q   <= start_ch;
            s_q    <= start_addr;
            k_q    <= '0;
            // num_taps=0 wraps to TAPS-1, which encodes a full-length kernel
            last_q <= num_taps - ADDR_W'(1);
          end
        end
        S_ISSUE: begin
          if (k_q == last_q) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            k_q <= k_q + ADDR_W'(1);
            s_q <= (s_q == last_q) ? '0 : s_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt) state <= S_OUT;
          drain_cnt <= 1'b1;
        end
        default: begin
          state        <= S_IDLE;
          result       <= sat_val;
          overflow     <= sat_flag;
          result_ch    <= ch_q;
          result_valid <= 1'b1;
        end
      endcase
    end
  end

  // Tap pipeline: address cycle -> RAM data (v1) -> registered product (v2) -> accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      prod <= '0;
      acc  <= '0;
    end else begin
      v1   <= (state == S_ISSUE);
      v2   <= v1;
      prod <= PROD_W'($signed(audio_data)) * PROD_W'($signed(kernel_data));
      if (accept)
        acc <= '0;
      else if (v2)
        acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine (TAPS=8, two channels) with sync-read RAM models.
module tb_fir_mac_engine;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 8;
  localparam int ADDR_W = 3;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   start;
  logic [CH_W-1:0]        start_ch;
  logic [ADDR_W-1:0]      start_addr;
  logic [ADDR_W-1:0]      num_taps;
  logic                   busy;
  logic [CH_W+ADDR_W-1:0] audio_addr;
  logic [DATA_W-1:0]      audio_data;
  logic [CH_W+ADDR_W-1:0] kernel_addr;
  logic [COEF_W-1:0]      kernel_data;
  logic [DATA_W-1:0]      result;
  logic [CH_W-1:0]        result_ch;
  logic                   result_valid;
  logic                   overflow;
  logic [1:0]             fsm_state;

  logic [DATA_W-1:0] amem [16];
  logic [COEF_W-1:0] kmem [16];
  int exp_aidx [8];
  int checks   = 0;
  int failures = 0;

  fir_mac_engine #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH), .CH_W(CH_W), .SHIFT(15), .ACC_W(DATA_W + COEF_W + ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_ch(start_ch),
    .start_addr(start_addr), .num_taps(num_taps), .busy(busy),
    .audio_addr(audio_addr), .audio_data(audio_data),
    .kernel_addr(kernel_addr), .kernel_data(kernel_data),
    .result(result), .result_ch(result_ch), .result_valid(result_valid),
    .overflow(overflow), .fsm_state(fsm_state)
  );

  // Clock and RAM models
  always #5 clk = ~clk;

  always @(posedge clk) begin
    audio_data  <= amem[audio_addr];
    kernel_data <= kmem[kernel_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      amem[i] = '0;
      kmem[i] = '0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_result_ch"}, 32'(result_ch), 32'd0);
    check({tag, "_aaddr"}, 32'(audio_addr), 32'd0);
    check({tag, "_kaddr"}, 32'(kernel_addr), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  // Issue one request, walk the run cycle by cycle and check timing and outcome.
  task automatic run_req(input string tag, input int ch, input int addr, input int nt,
                         input logic [15:0] exp_res, input logic exp_ovf,
                         input int inject_cyc, input bit chk_addr);
    int n;
    int vcnt;
    int vcyc;
    n    = (nt == 0) ? TAPS : nt;
    vcnt = 0;
    vcyc = -1;
    @(negedge clk);
    start      = 1'b1;
    start_ch   = CH_W'(ch);
    start_addr = ADDR_W'(addr);
    num_taps   = ADDR_W'(nt);
    @(posedge clk);
    @(negedge clk);
    for (int cyc = 1; cyc <= n + 8; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 1) begin
        start_addr = ADDR_W'(addr + 5);
        num_taps   = ADDR_W'(nt + 3);
      end
      if (cyc == inject_cyc) begin
        start    = 1'b1;
        start_ch = CH_W'(ch + 1);
      end else begin
        start = 1'b0;
      end
      if (result_valid) begin
        vcnt++;
        vcyc = cyc;
      end
      check({tag, "_busy"}, 32'(busy), (cyc <= n + 4) ? 32'd1 : 32'd0);
      if (cyc <= n) begin
        check({tag, "_aaddr_ch"}, 32'(audio_addr[ADDR_W]), 32'(ch));
        check({tag, "_kaddr_ch"}, 32'(kernel_addr[ADDR_W]), 32'(ch));
        if (chk_addr) begin
          check({tag, "_aaddr_idx"}, 32'(audio_addr[ADDR_W-1:0]), 32'(exp_aidx[cyc-1]));
          check({tag, "_kaddr_idx"}, 32'(kernel_addr[ADDR_W-1:0]), 32'(cyc - 1));
        end
      end
      if (cyc == n + 4) begin
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_result_ch"}, 32'(result_ch), 32'(ch));
      end
    end
    start = 1'b0;
    check({tag, "_valid_count"}, 32'(vcnt), 32'd1);
    check({tag, "_valid_cycle"}, 32'(vcyc), 32'(n + 4));
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    start_ch   = '0;
    start_addr = '0;
    num_taps   = '0;
    for (int i = 0; i < 8; i++) exp_aidx[i] = i;
    clear_mem();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Basic product: 0x4000*0x4000 = 2^28, >>15 -> 0x2000
    clear_mem();
    amem[0] = 16'h4000; kmem[0] = 16'h4000;
    run_req("basic", 0, 0, 1, 16'h2000, 1'b0, 0, 1'b0);

    // Wrap: N=4 from index 2 -> 2,3,0,1; 3*0x4000 + 4*0x2000 = 81920 -> 3
    clear_mem();
    amem[0] = 16'd1; amem[1] = 16'd2; amem[2] = 16'd3; amem[3] = 16'd4;
    for (int i = 4; i < 8; i++) amem[i] = 16'd100;
    kmem[0] = 16'h4000; kmem[1] = 16'h2000;
    exp_aidx[0] = 2; exp_aidx[1] = 3; exp_aidx[2] = 0; exp_aidx[3] = 1;
    run_req("wrap", 0, 2, 4, 16'd3, 1'b0, 0, 1'b1);

    // Positive saturation
    clear_mem();
    for (int i = 0; i < 4; i++) begin amem[i] = 16'h7FFF; kmem[i] = 16'h7FFF; end
    run_req("sat_pos", 0, 0, 4, 16'h7FFF, 1'b1, 0, 1'b0);

    // Negative saturation
    for (int i = 0; i < 4; i++) amem[i] = 16'h8000;
    run_req("sat_neg", 0, 0, 4, 16'h8000, 1'b1, 0, 1'b0);

    // Rounding: 0x4000/2^15 = 0.5 rounds up to 1; 0x3FFF rounds down to 0
    clear_mem();
    amem[0] = 16'd1; kmem[0] = 16'h4000;
    run_req("round_up", 0, 0, 1, 16'd1, 1'b0, 0, 1'b0);
    kmem[0] = 16'h3FFF;
    run_req("round_down", 0, 0, 1, 16'd0, 1'b0, 0, 1'b0);

    // Channel 1, N=3, stray start for channel 0 during busy: 3*2^16 -> 6
    clear_mem();
    for (int i = 8; i < 11; i++) begin amem[i] = 16'h0100; kmem[i] = 16'h0100; end
    run_req("chan", 1, 0, 3, 16'd6, 1'b0, 2, 1'b0);

    // Reset mid-run: N=8 (num_taps=0) on channel 1, reset in cycle 2
    @(negedge clk);
    start = 1'b1; start_ch = 1'b1; start_addr = '0; num_taps = '0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    check("midrun_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrun_hold_valid", 32'(result_valid), 32'd0);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("midrun_after_valid", 32'(result_valid), 32'd0);
      check("midrun_after_busy", 32'(busy), 32'd0);
    end

    // New request after reset completes normally
    clear_mem();
    amem[0] = 16'h4000; kmem[0] = 16'h4000;
    run_req("post_reset", 0, 0, 1, 16'h2000, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
# fir_mac_engine

Parametrised multi-channel FIR engine; successor to the single-channel 16-bit FIR filter. It computes one output sample per `start` request as the signed dot product of a circular sample window and a coefficient kernel, both held in external synchronous-read RAMs. It sits between the per-channel audio sample buffers and the effects output mixer. It adds run-time tap count, channel select, a start/busy/valid handshake, rounding, and saturation.

## Interface
- `DATA_W`, 16: sample and result width, signed two's complement.
- `COEF_W`, 16: coefficient width, signed.
- `TAPS`, 128: maximum tap count; power of 2.
- `ADDR_W`, clog2(TAPS): per-channel index width.
- `NUM_CH`, 2: channel count.
- `CH_W`, max(1, clog2(NUM_CH)): channel field width.
- `SHIFT`, 15: result scaling (right shift) applied to the accumulator.
- `ACC_W`, DATA_W+COEF_W+ADDR_W: accumulator width; guard bits make overflow impossible.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one output sample; accepted only when `busy`=0.
- `start_ch`  in  CH_W  channel for the request.
- `start_addr`  in  ADDR_W  sample index paired with kernel tap 0.
- `num_taps`  in  ADDR_W  effective tap count N; 0 encodes TAPS.
- `busy`  out  1  high while a request is in flight.
- `audio_addr`  out  CH_W+ADDR_W  {channel, sample index} to the sample RAM.
- `audio_data`  in  DATA_W  sample RAM read data, valid one cycle after address.
- `kernel_addr`  out  CH_W+ADDR_W  {channel, tap index} to the coefficient RAM.
- `kernel_data`  in  COEF_W  coefficient RAM read data, valid one cycle after address.
- `result`  out  DATA_W  scaled and saturated output; held until the next result.
- `result_ch`  out  CH_W  channel of `result`.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `overflow`  out  1  high with `result_valid` if saturation occurred; held with `result`.

## Operation
- States:
  - IDLE: accepts a request.
  - ISSUE: presents N address pairs.
  - DRAIN: waits for the pipeline to empty.
  - OUT: registers `result` and pulses `result_valid`.
  - Transitions: IDLE→ISSUE on `start`; ISSUE→DRAIN after the N-th address; DRAIN→OUT after 2 cycles; OUT→IDLE.
- On accept, latch `start_ch`, `start_addr` and N; clear the accumulator.
- ISSUE, address step k = 0..N-1:
  - Kernel index = k.
  - Sample index starts at `start_addr`; after index N-1 it wraps to 0, otherwise it increments modulo 2^ADDR_W.
  - Channel bits of both addresses = latched channel.
- Pipeline per tap: address → RAM data (+1) → registered signed product, DATA_W+COEF_W bits (+1) → accumulator add, sign-extended to ACC_W (+1).
- Result computation:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up).
  - If r > 2^(DATA_W-1)-1, result = 0x7FFF (for DATA_W=16) and `overflow`=1.
  - If r < -2^(DATA_W-1), result = 0x8000 and `overflow`=1.
  - Otherwise result = r and `overflow`=0.
- `start` while `busy`=1 is ignored; no queueing.
- Out-of-range `start_addr` (≥ N) is not an error: the index counts up modulo 2^ADDR_W until it equals N-1, then wraps to 0. Exactly N products are always summed.
- `num_taps`, `start_ch` and `start_addr` are sampled only at accept; later changes do not affect a run in flight.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - State = IDLE.
  - `busy`, `result_valid`, `overflow` = 0.
  - `result`, `result_ch`, `audio_addr`, `kernel_addr` = 0.
  - A run in flight is aborted with no `result_valid`.
- Accept edge = cycle 0. Addresses for tap k are stable during cycle k+1.
- `busy` is high during cycles 1..N+4.
- `result_valid` is high in cycle N+4 only.
- `busy`=0 from cycle N+5; the earliest next accept is the edge ending cycle N+5. Throughput is one result per N+5 cycles.
- Address outputs hold their last value outside ISSUE.

## Test plan
- Basic product: N=1, `audio_data`=0x4000, `kernel_data`=0x4000 → `result`=0x2000, `overflow`=0, `result_valid` in cycle 5 only.
- Wrap: TAPS=8, N=4, `start_addr`=2 → `audio_addr` indices 2,3,0,1 and `kernel_addr` indices 0,1,2,3 in cycles 1-4.
- Saturation:
  - Positive: N=4, all samples 0x7FFF, all coefficients 0x7FFF → `result`=0x7FFF, `overflow`=1.
  - Negative: samples 0x8000, coefficients 0x7FFF → `result`=0x8000, `overflow`=1.
- Rounding: N=1, sample 1, coefficient 0x4000 → `result`=1. Sample 1, coefficient 0x3FFF → `result`=0.
- Channel and busy handling:
  - Request with `start_ch`=1, N=3; pulse `start` with `start_ch`=0 during `busy`.
  - Required: address channel bits stay 1, exactly one `result_valid`, `result_ch`=1.
- Reset mid-run: drop `reset_n` in cycle 2 of an N=8 run.
  - Required: all outputs 0 immediately, no `result_valid`.
  - After release, a new N=1 request completes normally in 5 cycles.
